// File: rtl/analog_mux_seq_pkg.sv
// Shared types, default parameter values and the round-robin pick helper
// for the analog mux sequencer.
package analog_mux_seq_pkg;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_BBM_CYCLES    = 2;
  localparam int DEF_MIN_DWELL     = 4;
  localparam int DEF_MAX_DWELL     = 16;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int MAX_CH            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BREAK = 2'd2
  } seq_state_e;

  // Returns {valid, idx[2:0]}: first set request after ptr, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [3:0] res;
    logic [2:0] cand;
    res = 4'd0;
    for (int k = 1; k <= MAX_CH; k++) begin
      cand = 3'((int'(ptr) + k) % n);
      if ((k <= n) && !res[3] && req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/analog_mux_sequencer_rr_arbiter_onehot.sv
// Combinational round-robin select: winner index plus one-hot form.
module rr_arbiter_onehot
  import analog_mux_seq_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N_CH-1:0]  onehot
);

  logic [3:0]        pick_s;
  logic [MAX_CH-1:0] req_ext_s;
  logic [2:0]        ptr_ext_s;

  // Widen inputs to the helper's fixed width and decode its result.
  always_comb begin
    req_ext_s              = '0;
    req_ext_s[N_CH-1:0]    = req;
    ptr_ext_s              = 3'd0;
    ptr_ext_s[IDX_W-1:0]   = ptr;
    pick_s                 = rr_pick(req_ext_s, ptr_ext_s, N_CH);
    valid                  = pick_s[3];
    idx                    = pick_s[IDX_W-1:0];
    onehot                 = '0;
    if (pick_s[3]) begin
      onehot[pick_s[IDX_W-1:0]] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/analog_mux_sequencer.sv
// Time-shares one analog bus among N_CH mux switches with round-robin
// arbitration, break-before-make gaps and min/max dwell per grant.
// Optional settle qualifier output enabled by ANALOG_MUX_SEQ_SETTLE_EN.
module analog_mux_sequencer
  import analog_mux_seq_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int BBM_CYCLES = DEF_BBM_CYCLES,
  parameter int MIN_DWELL  = DEF_MIN_DWELL,
  parameter int MAX_DWELL  = DEF_MAX_DWELL,
  parameter int IDX_W      = $clog2(N_CH)
`ifdef ANALOG_MUX_SEQ_SETTLE_EN
  ,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  output logic [N_CH-1:0]  ctrl,
  output logic [IDX_W-1:0] grant_idx,
  output logic             active,
  output logic             gap
`ifdef ANALOG_MUX_SEQ_SETTLE_EN
  ,
  output logic             settled
`endif
);

  localparam int DWELL_TOP = (MAX_DWELL > MIN_DWELL) ? MAX_DWELL : MIN_DWELL;
  localparam int DWELL_W   = $clog2(DWELL_TOP + 1);
  localparam int GAP_W     = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] MIN_LAST = DWELL_W'(MIN_DWELL - 1);
  localparam logic [DWELL_W-1:0] MAX_LAST = DWELL_W'((MAX_DWELL == 0) ? 0 : MAX_DWELL - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(BBM_CYCLES - 1);

  seq_state_e         state_r, state_nx_s;
  logic [IDX_W-1:0]   rr_ptr_r, ptr_nx_s;
  logic [DWELL_W-1:0] dwell_r, dwell_nx_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_nx_s;
  logic [N_CH-1:0]    ctrl_nx_s;
  logic [IDX_W-1:0]   grant_nx_s;
  logic               gap_nx_s;
  logic               win_valid_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [N_CH-1:0]    win_onehot_s;
  logic               own_req_s, other_req_s, release_s;
`ifdef ANALOG_MUX_SEQ_SETTLE_EN
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  logic [SET_W-1:0]   settle_cnt_r, settle_nx_s;
  logic               settled_nx_s;
`endif

  rr_arbiter_onehot #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
    .req    (req),
    .ptr    (rr_ptr_r),
    .valid  (win_valid_s),
    .idx    (win_idx_s),
    .onehot (win_onehot_s)
  );

  // Release decision for the channel currently driving the bus.
  always_comb begin
    own_req_s   = |(req & ctrl);
    other_req_s = |(req & ~ctrl);
    release_s   = 1'b0;
    if (state_r == ON) begin
      release_s = ((dwell_r >= MIN_LAST) && !own_req_s) ||
                  ((MAX_DWELL != 0) && (dwell_r == MAX_LAST) && other_req_s);
    end else begin
      release_s = 1'b0;
    end
  end

  // Next-state and next-output logic of the grant sequencer.
  always_comb begin
    state_nx_s   = state_r;
    ctrl_nx_s    = ctrl;
    grant_nx_s   = grant_idx;
    ptr_nx_s     = rr_ptr_r;
    dwell_nx_s   = dwell_r;
    gap_cnt_nx_s = gap_cnt_r;
    gap_nx_s     = gap;
    case (state_r)
      IDLE, BREAK: begin
        if ((state_r == BREAK) && (gap_cnt_r != '0)) begin
          gap_cnt_nx_s = gap_cnt_r - GAP_W'(1);
          ctrl_nx_s    = '0;
          gap_nx_s     = 1'b1;
        end else if (win_valid_s) begin
          state_nx_s   = ON;
          ctrl_nx_s    = win_onehot_s;
          grant_nx_s   = win_idx_s;
          ptr_nx_s     = win_idx_s;
          dwell_nx_s   = '0;
          gap_nx_s     = 1'b0;
        end else begin
          state_nx_s   = IDLE;
          ctrl_nx_s    = '0;
          gap_nx_s     = 1'b0;
        end
      end
      ON: begin
        if (release_s) begin
          state_nx_s   = BREAK;
          ctrl_nx_s    = '0;
          gap_nx_s     = 1'b1;
          gap_cnt_nx_s = GAP_LOAD;
        end else if (dwell_r != '1) begin
          dwell_nx_s   = dwell_r + DWELL_W'(1);
        end else begin
          dwell_nx_s   = dwell_r;
        end
      end
      default: begin
        state_nx_s   = IDLE;
        ctrl_nx_s    = '0;
        gap_nx_s     = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= IDX_W'(N_CH - 1);
      dwell_r   <= '0;
      gap_cnt_r <= '0;
      ctrl      <= '0;
      grant_idx <= '0;
      active    <= 1'b0;
      gap       <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      rr_ptr_r  <= ptr_nx_s;
      dwell_r   <= dwell_nx_s;
      gap_cnt_r <= gap_cnt_nx_s;
      ctrl      <= ctrl_nx_s;
      grant_idx <= grant_nx_s;
      active    <= |ctrl_nx_s;
      gap       <= gap_nx_s;
    end
  end

`ifdef ANALOG_MUX_SEQ_SETTLE_EN
  // Settle counter: runs while a grant continues, clears on grant or release.
  always_comb begin
    settle_nx_s  = '0;
    settled_nx_s = 1'b0;
    if ((state_r == ON) && !release_s) begin
      settle_nx_s  = (settle_cnt_r == SET_W'(SETTLE_CYCLES)) ? settle_cnt_r
                                                            : settle_cnt_r + SET_W'(1);
      settled_nx_s = (settle_nx_s == SET_W'(SETTLE_CYCLES));
    end else begin
      settle_nx_s  = '0;
      settled_nx_s = 1'b0;
    end
  end

  // Registered settle qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= '0;
      settled      <= 1'b0;
    end else begin
      settle_cnt_r <= settle_nx_s;
      settled      <= settled_nx_s;
    end
  end
`endif

endmodule

// File: tb/tb_analog_mux_sequencer.sv
// Self-checking bench: dut_a uses MAX_DWELL=16, dut_b uses MAX_DWELL=0.
module tb_analog_mux_sequencer;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req_a, req_b, ctrl_a, ctrl_b;
  logic [1:0] idx_a, idx_b;
  logic       active_a, active_b, gap_a, gap_b;
`ifdef ANALOG_MUX_SEQ_SETTLE_EN
  logic       settled_a, settled_b;
`endif

  analog_mux_sequencer #(.N_CH(4), .BBM_CYCLES(2), .MIN_DWELL(4), .MAX_DWELL(16)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .ctrl(ctrl_a), .grant_idx(idx_a),
    .active(active_a), .gap(gap_a)
`ifdef ANALOG_MUX_SEQ_SETTLE_EN
    , .settled(settled_a)
`endif
  );

  analog_mux_sequencer #(.N_CH(4), .BBM_CYCLES(2), .MIN_DWELL(4), .MAX_DWELL(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .ctrl(ctrl_b), .grant_idx(idx_b),
    .active(active_b), .gap(gap_b)
`ifdef ANALOG_MUX_SEQ_SETTLE_EN
    , .settled(settled_b)
`endif
  );

  // Reference model: who owns the bus, how many cycles it has held it,
  // how many gap cycles remain, last winner, and the visible grant index.
  typedef struct {
    int owner;
    int held;
    int gap_left;
    int last;
    int idx;
  } mst_t;

  typedef struct {
    logic       rs;
    logic [3:0] r;
    logic [3:0] c;
    logic [1:0] ix;
    logic       g;
  } vec_t;

  mst_t ma, mb;
  int   errors = 0;
  int   checks = 0;

  function automatic int pick(input logic [3:0] r, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic mst_t step(input mst_t s, input logic [3:0] r, input logic rs,
                                input int max_dwell);
    mst_t n;
    int   w;
    logic others;
    n = s;
    if (rs) begin
      n.owner = -1; n.held = 0; n.gap_left = 0; n.last = N - 1; n.idx = 0;
      return n;
    end
    if (s.owner >= 0) begin
      others = (r & ~(4'b0001 << s.owner)) != 4'b0000;
      if ((s.held >= 4 && !r[s.owner]) || (max_dwell != 0 && s.held == max_dwell && others)) begin
        n.owner = -1;
        n.gap_left = 2;
      end else begin
        n.held = s.held + 1;
      end
    end else if (s.gap_left > 1) begin
      n.gap_left = s.gap_left - 1;
    end else begin
      n.gap_left = 0;
      w = pick(r, s.last);
      if (w >= 0) begin
        n.owner = w; n.held = 1; n.last = w; n.idx = w;
      end
    end
    return n;
  endfunction

  task automatic check_one(input string nm, input mst_t m, input logic [3:0] c,
                           input logic [1:0] ix, input logic act, input logic g);
    logic [3:0] ec;
    ec = (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
    checks++;
    if (c !== ec || ix !== 2'(m.idx) || act !== (ec != 4'b0000) || g !== (m.gap_left > 0) ||
        $countones(c) > 1) begin
      errors++;
      $display("FAIL %s t=%0t: ctrl=%b idx=%0d active=%b gap=%b, expected ctrl=%b idx=%0d active=%b gap=%b",
               nm, $time, c, ix, act, g, ec, m.idx, ec != 4'b0000, m.gap_left > 0);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Advance one clock: model steps on the same inputs the DUTs sample,
  // outputs are compared on the falling edge.
  task automatic tick();
    ma = step(ma, req_a, rst, 16);
    mb = step(mb, req_b, rst, 0);
    @(posedge clk);
    @(negedge clk);
    check_one("model_a", ma, ctrl_a, idx_a, active_a, gap_a);
    check_one("model_b", mb, ctrl_b, idx_b, active_b, gap_b);
`ifdef ANALOG_MUX_SEQ_SETTLE_EN
    checks++;
    if (settled_a !== (ma.owner >= 0 && ma.held >= 4)) begin
      errors++;
      $display("FAIL settled_a: got %b expected %b", settled_a, ma.owner >= 0 && ma.held >= 4);
    end
`endif
  endtask

  vec_t tbl[13];
  int   order[$];
  int   run_len, on_cnt;
  logic [3:0] prev;

  initial begin
    ma = '{owner: -1, held: 0, gap_left: 0, last: N - 1, idx: 0};
    mb = ma;
    rst = 1'b1; req_a = 4'b0000; req_b = 4'b0000;
    @(negedge clk);

    // Reset then 20 idle cycles.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Directed vectors: short request, BBM gap, reset mid-ON, first winner after reset.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0010, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0010, 2'd1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b0010, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 4'b0001, 2'd0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rs; req_a = tbl[i].r;
      tick();
      checks++;
      if (ctrl_a !== tbl[i].c || idx_a !== tbl[i].ix || gap_a !== tbl[i].g) begin
        errors++;
        $display("FAIL vec%0d: ctrl=%b idx=%0d gap=%b expected ctrl=%b idx=%0d gap=%b",
                 i, ctrl_a, idx_a, gap_a, tbl[i].c, tbl[i].ix, tbl[i].g);
      end
    end

    // Rotation with all channels requesting.
    rst = 1'b1; req_a = 4'b0000; tick();
    rst = 1'b0; req_a = 4'b1111;
    prev = 4'b0000; run_len = 0;
    for (int i = 0; i < 120 && order.size() < 5; i++) begin
      tick();
      if (ctrl_a != 4'b0000 && prev == 4'b0000) begin
        order.push_back($clog2(ctrl_a));
        run_len = 1;
      end else if (ctrl_a != 4'b0000) begin
        run_len++;
      end else if (prev != 4'b0000) begin
        chk_int("rot_on_len", run_len, 16);
      end
      prev = ctrl_a;
    end
    chk_int("rot_count", order.size(), 5);
    for (int i = 0; i < order.size(); i++) chk_int("rot_order", order[i], i % 4);

    // Preemption: ch2 holding, ch0 arrives at dwell 5.
    rst = 1'b1; req_a = 4'b0000; tick();
    rst = 1'b0; req_a = 4'b0100; tick();
    on_cnt = 1;
    for (int i = 0; i < 5; i++) begin tick(); on_cnt++; end
    req_a = 4'b0101;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ctrl_a != 4'b0100) break;
      on_cnt++;
    end
    chk_int("preempt_len", on_cnt, 16);
    chk4("preempt_gap1", {3'b000, gap_a}, 4'b0001);
    tick();
    chk4("preempt_gap2", ctrl_a, 4'b0000);
    tick();
    chk4("preempt_ch0", ctrl_a, 4'b0001);

    // Unlimited dwell on dut_b: ch3 never preempted by ch1.
    rst = 1'b1; req_a = 4'b0000; req_b = 4'b0000; tick();
    rst = 1'b0; req_b = 4'b1000; tick();
    req_b = 4'b1010;
    on_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ctrl_b == 4'b1000) on_cnt++;
    end
    chk_int("nomax_hold", on_cnt, 100);
    req_b = 4'b0010;
    tick(); chk4("nomax_gap1", ctrl_b, 4'b0000);
    tick(); chk4("nomax_gap2", ctrl_b, 4'b0000);
    tick(); chk4("nomax_ch1", ctrl_b, 4'b0010);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) req_a = 4'($urandom);
      if ($urandom_range(0, 7) == 0) req_b = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
